// File: rtl/multi_digit_display.sv
// Sequential N-digit decimal-to-7-segment driver: one digit per clock, LSB first,
// published atomically. Define LEADING_ZEROS_EN to show zeros instead of blanks.

module digit_display (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  // Decimal digit to segment pattern; codes above 9 are blank
  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h0C;
      4'd2:    seg = 7'h76;
      4'd3:    seg = 7'h5E;
      4'd4:    seg = 7'h4D;
      4'd5:    seg = 7'h5B;
      4'd6:    seg = 7'h7B;
      4'd7:    seg = 7'h0E;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h5F;
      default: seg = 7'h00;
    endcase
  end
endmodule

module multi_digit_display #(
  parameter int NUMBER_WIDTH = 16,
  parameter int DIGITS       = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUMBER_WIDTH-1:0] number,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*DIGITS-1:0]     segments
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUMBER_WIDTH-1:0] work_q, work_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7*DIGITS-1:0]     shadow_q, shadow_d;
  logic [7*DIGITS-1:0]     segments_q, segments_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;

  logic [NUMBER_WIDTH-1:0] quot_s;
  logic [3:0]              digit_s;
  logic [6:0]              pattern_s;
  logic [6:0]              digit_seg_s;

  assign quot_s  = work_q / NUMBER_WIDTH'(10);
  assign digit_s = 4'(work_q % NUMBER_WIDTH'(10));

  digit_display u_dec (
    .digit (digit_s),
    .seg   (pattern_s)
  );

  // Blank a position once the remaining value is exhausted (digit 0 always shows)
  always_comb begin
    digit_seg_s = pattern_s;
`ifdef LEADING_ZEROS_EN
    digit_seg_s = pattern_s;
`else
    if ((work_q != {NUMBER_WIDTH{1'b0}}) || (idx_q == {IDX_W{1'b0}})) begin
      digit_seg_s = pattern_s;
    end else begin
      digit_seg_s = 7'h00;
    end
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    segments_d = segments_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = number;
          idx_d   = {IDX_W{1'b0}};
          busy_d  = 1'b1;
          state_d = CONVERT;
        end else begin
          busy_d  = 1'b0;
        end
      end
      CONVERT: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (idx_q == IDX_W'(k)) begin
            shadow_d[7*k +: 7] = digit_seg_s;
          end else begin
            shadow_d[7*k +: 7] = shadow_q[7*k +: 7];
          end
        end
        work_d = quot_s;
        // Publish on the same edge the last digit lands so done and segments coincide
        if (idx_q == LAST_IDX) begin
          idx_d      = {IDX_W{1'b0}};
          segments_d = shadow_d;
          overflow_d = (quot_s != {NUMBER_WIDTH{1'b0}});
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = PUBLISH;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
        end
      end
      PUBLISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= {NUMBER_WIDTH{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      shadow_q   <= {(7*DIGITS){1'b0}};
      segments_q <= {(7*DIGITS){1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      segments_q <= segments_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign segments = segments_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Randomized self-checking bench for multi_digit_display (5-digit and 4-digit instances).

module tb_multi_digit_display;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] number = 16'd0;
  logic        start = 1'b0;
  logic        busy5, done5, ovf5, busy4, done4, ovf4;
  logic [34:0] seg5;
  logic [27:0] seg4;
  int total = 0;
  int bad = 0;
  logic [34:0] prev5 = 35'd0;
  logic [27:0] prev4 = 28'd0;
  logic        prevo5 = 1'b0;
  logic        prevo4 = 1'b0;

  always #5 clk = ~clk;

  multi_digit_display #(.NUMBER_WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .number(number), .start(start),
    .busy(busy5), .done(done5), .overflow(ovf5), .segments(seg5));

  multi_digit_display #(.NUMBER_WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .number(number), .start(start),
    .busy(busy4), .done(done4), .overflow(ovf4), .segments(seg4));

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h0C; 2: return 7'h76; 3: return 7'h5E;
      4: return 7'h4D; 5: return 7'h5B; 6: return 7'h7B; 7: return 7'h0E;
      8: return 7'h7F; 9: return 7'h5F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic longint pow10(input int k);
    longint p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Digit k is (v / 10^k) mod 10, visible when v reaches 10^k (or always with leading zeros)
  function automatic logic [34:0] exp_seg(input longint v, input int n);
    logic [34:0] r = 35'd0;
    for (int k = 0; k < n; k++) begin
      longint p = pow10(k);
`ifdef LEADING_ZEROS_EN
      r[7*k +: 7] = pat(int'((v / p) % 10));
`else
      if (k == 0 || v >= p) r[7*k +: 7] = pat(int'((v / p) % 10));
`endif
    end
    return r;
  endfunction

  function automatic logic exp_ovf(input longint v, input int n);
    return v >= pow10(n);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; number = 16'd1234;
    repeat (2) @(negedge clk);
    total++; if (seg5 !== 35'd0) begin bad++; $display("FAIL reset_seg5 got=%h exp=0", seg5); end
    total++; if (seg4 !== 28'd0) begin bad++; $display("FAIL reset_seg4 got=%h exp=0", seg4); end
    total++; if ({busy5, done5, ovf5} !== 3'b000) begin bad++; $display("FAIL reset_flags5 got=%b exp=000", {busy5, done5, ovf5}); end
    total++; if ({busy4, done4, ovf4} !== 3'b000) begin bad++; $display("FAIL reset_flags4 got=%b exp=000", {busy4, done4, ovf4}); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  // One conversion, checked every cycle; optional extra start while busy at sample extra_at
  task automatic run_conv(input logic [15:0] v, input int extra_at, input logic [15:0] extra_v);
    logic [34:0] e5 = exp_seg(longint'(v), 5);
    logic [34:0] e4w = exp_seg(longint'(v), 4);
    logic [27:0] e4 = e4w[27:0];
    logic eo5 = exp_ovf(longint'(v), 5);
    logic eo4 = exp_ovf(longint'(v), 4);
    number = v; start = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      @(negedge clk);
      total++; if (busy5 !== (s <= 5)) begin bad++; $display("FAIL busy5 v=%0d s=%0d got=%b", v, s, busy5); end
      total++; if (done5 !== (s == 6)) begin bad++; $display("FAIL done5 v=%0d s=%0d got=%b", v, s, done5); end
      total++; if (seg5 !== ((s >= 6) ? e5 : prev5)) begin bad++; $display("FAIL seg5 v=%0d s=%0d got=%h exp=%h", v, s, seg5, (s >= 6) ? e5 : prev5); end
      total++; if (ovf5 !== ((s >= 6) ? eo5 : prevo5)) begin bad++; $display("FAIL ovf5 v=%0d s=%0d got=%b", v, s, ovf5); end
      total++; if (busy4 !== (s <= 4)) begin bad++; $display("FAIL busy4 v=%0d s=%0d got=%b", v, s, busy4); end
      total++; if (done4 !== (s == 5)) begin bad++; $display("FAIL done4 v=%0d s=%0d got=%b", v, s, done4); end
      total++; if (seg4 !== ((s >= 5) ? e4 : prev4)) begin bad++; $display("FAIL seg4 v=%0d s=%0d got=%h exp=%h", v, s, seg4, (s >= 5) ? e4 : prev4); end
      total++; if (ovf4 !== ((s >= 5) ? eo4 : prevo4)) begin bad++; $display("FAIL ovf4 v=%0d s=%0d got=%b", v, s, ovf4); end
      start = 1'b0;
      number = 16'($urandom);
      if (s == extra_at) begin start = 1'b1; number = extra_v; end
    end
    prev5 = e5; prev4 = e4; prevo5 = eo5; prevo4 = eo4;
  endtask

  task automatic test_directed();
    logic [15:0] vals [8] = '{16'd1234, 16'd0, 16'd65535, 16'd9, 16'd10, 16'd9999, 16'd10000, 16'd100};
    foreach (vals[i]) run_conv(vals[i], 0, 16'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++) run_conv(16'($urandom), 0, 16'd0);
  endtask

  task automatic test_busy_ignore();
    run_conv(16'd1234, 0, 16'd0);
    run_conv(16'd7, 2, 16'd9);
  endtask

  task automatic test_reset_mid();
    number = 16'd1234; start = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      if (s == 4) begin
        total++; if (seg5 !== 35'd0 || seg4 !== 28'd0) begin bad++; $display("FAIL rstmid_seg got=%h/%h exp=0", seg5, seg4); end
        total++; if ({busy5, done5, ovf5, busy4, done4, ovf4} !== 6'd0) begin bad++; $display("FAIL rstmid_flags got=%b exp=0", {busy5, done5, ovf5, busy4, done4, ovf4}); end
      end
      if (s > 4) begin
        total++; if (done5 !== 1'b0 || done4 !== 1'b0 || busy5 !== 1'b0) begin bad++; $display("FAIL rstmid_nodone s=%0d got=%b%b%b", s, done5, done4, busy5); end
      end
      start = 1'b0;
      rst = (s == 3);
    end
    prev5 = 35'd0; prev4 = 28'd0; prevo5 = 1'b0; prevo4 = 1'b0;
    run_conv(16'd56, 0, 16'd0);
  endtask

  // start held high: re-accepted right after each publish cycle
  task automatic test_back_to_back();
    logic [15:0] v1 = 16'($urandom);
    logic [15:0] v2 = 16'($urandom);
    logic [34:0] a5 = exp_seg(longint'(v1), 5);
    logic [34:0] b5 = exp_seg(longint'(v2), 5);
    logic [34:0] a4 = exp_seg(longint'(v1), 4);
    logic [34:0] b4 = exp_seg(longint'(v2), 4);
    number = v1; start = 1'b1;
    for (int s = 1; s <= 14; s++) begin
      @(negedge clk);
      total++; if (done5 !== (s == 6 || s == 13)) begin bad++; $display("FAIL b2b_done5 s=%0d got=%b", s, done5); end
      total++; if (done4 !== (s == 5 || s == 11)) begin bad++; $display("FAIL b2b_done4 s=%0d got=%b", s, done4); end
      if (s == 6 || s == 13) begin
        total++; if (seg5 !== ((s == 6) ? a5 : b5)) begin bad++; $display("FAIL b2b_seg5 s=%0d got=%h exp=%h", s, seg5, (s == 6) ? a5 : b5); end
      end
      if (s == 5 || s == 11) begin
        total++; if (seg4 !== ((s == 5) ? a4[27:0] : b4[27:0])) begin bad++; $display("FAIL b2b_seg4 s=%0d got=%h exp=%h", s, seg4, (s == 5) ? a4[27:0] : b4[27:0]); end
      end
      if (s == 1) number = v2;
      if (s == 14) start = 1'b0;
    end
    repeat (8) @(negedge clk);
    prev5 = b5; prev4 = b4[27:0];
    prevo5 = exp_ovf(longint'(v2), 5); prevo4 = exp_ovf(longint'(v2), 4);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    run_conv(16'd4242, 0, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
